// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared definitions for the WS2812 (NeoPixel) receive path.
//   - cycle-count constant functions for the line timing thresholds,
//     derived from the system clock frequency (rounded down)
//   - receiver state encoding
//   - GRB field offsets within a 24-bit pixel word (shared with the transmitter)
package ws2812_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_STUCK,
        ST_LATCH
    } ws2812_state_t;

    localparam int unsigned GRB_PIX_W   = 24;
    localparam int unsigned GRB_FIELD_W = 8;
    localparam int unsigned GRB_G_LSB   = 16;
    localparam int unsigned GRB_R_LSB   = 8;
    localparam int unsigned GRB_B_LSB   = 0;

    function automatic int unsigned cycles_ns(input longint unsigned clk_hz,
                                              input longint unsigned ns);
        longint unsigned prod;
        prod = (clk_hz * ns) / 64'd1000000000;
        return 32'(prod);
    endfunction

    function automatic int unsigned t_min(input longint unsigned clk_hz);
        return cycles_ns(clk_hz, 64'd150);
    endfunction

    function automatic int unsigned t_thresh(input longint unsigned clk_hz);
        return cycles_ns(clk_hz, 64'd600);
    endfunction

    function automatic int unsigned t_max(input longint unsigned clk_hz);
        return cycles_ns(clk_hz, 64'd2000);
    endfunction

    function automatic int unsigned t_reset(input longint unsigned clk_hz);
        return cycles_ns(clk_hz, 64'd50000);
    endfunction

endpackage

// File: rtl/ws2812_pulse_timer.sv
// ws2812_pulse_timer: input conditioning and pulse timing for the WS2812 line.
//   i_clk    system clock
//   i_rst    asynchronous active-high reset
//   i_di     raw data line, asynchronous to i_clk
//   o_di_s   synchronized data line (2-flop synchronizer output)
//   o_rise   one-cycle strobe on a rising edge of o_di_s
//   o_fall   one-cycle strobe on a falling edge of o_di_s
//   o_count  cycles since the last edge, minus one while the strobe is up;
//            cleared on each edge, saturates at CNT_MAX
module ws2812_pulse_timer #(
    parameter int unsigned CNT_MAX = 2500,
    parameter int unsigned CNT_W   = $clog2(CNT_MAX + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_di,
    output logic             o_di_s,
    output logic             o_rise,
    output logic             o_fall,
    output logic [CNT_W-1:0] o_count
);

    logic [1:0]       r_sync;
    logic             r_di_d;
    logic [CNT_W-1:0] r_cnt;
    logic             w_edge;

    assign o_di_s  = r_sync[1];
    assign o_rise  = r_sync[1] & ~r_di_d;
    assign o_fall  = ~r_sync[1] & r_di_d;
    assign w_edge  = r_sync[1] ^ r_di_d;
    assign o_count = r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_di_d <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_di};
            r_di_d <= r_sync[1];
            if (w_edge) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_W'(CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a single-wire WS2812 bitstream into 24-bit GRB pixel words.
//   clk_i        system clock (SYSTEM_CLOCK Hz)
//   reset_i      asynchronous active-high reset
//   di_i         raw NeoPixel data line
//   pix_valid_o  one-cycle pulse, pixel word valid on pix_data_o/pix_index_o
//   pix_data_o   {green, red, blue}, first wire bit in bit 23
//   pix_index_o  pixel position within the frame, 0 after each latch
//   latch_o      one-cycle pulse when a reset gap ends a frame
//   pix_count_o  complete pixels of the last frame (saturates at NUM_LEDS)
//   err_o        sticky error, re-evaluated at every latch_o
//   busy_o       frame in progress
//   do_o         forwarded data line
// Build option WS2812_RX_FORWARD_EN: pass pixels beyond NUM_LEDS to do_o
// instead of flagging them as errors; otherwise do_o is tied low.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS     = 8,
    parameter int unsigned SYSTEM_CLOCK = 50000000
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        di_i,
    output logic                        pix_valid_o,
    output logic [GRB_PIX_W-1:0]        pix_data_o,
    output logic [$clog2(NUM_LEDS)-1:0] pix_index_o,
    output logic                        latch_o,
    output logic [$clog2(NUM_LEDS):0]   pix_count_o,
    output logic                        err_o,
    output logic                        busy_o,
    output logic                        do_o
);

    localparam int unsigned T_MIN_C    = t_min(64'(SYSTEM_CLOCK));
    localparam int unsigned T_THRESH_C = t_thresh(64'(SYSTEM_CLOCK));
    localparam int unsigned T_MAX_C    = t_max(64'(SYSTEM_CLOCK));
    localparam int unsigned T_RESET_C  = t_reset(64'(SYSTEM_CLOCK));
    localparam int unsigned CW         = $clog2(T_RESET_C + 1);
    localparam int unsigned IW         = $clog2(NUM_LEDS);
    localparam int unsigned PW         = IW + 1;

    logic          w_di_s;
    logic          w_rise;
    logic          w_fall;
    logic [CW-1:0] w_count;

    ws2812_pulse_timer #(
        .CNT_MAX (T_RESET_C),
        .CNT_W   (CW)
    ) u_timer (
        .i_clk   (clk_i),
        .i_rst   (reset_i),
        .i_di    (di_i),
        .o_di_s  (w_di_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall),
        .o_count (w_count)
    );

    ws2812_state_t        r_state;
    ws2812_state_t        w_next;
    logic                 w_take_bit;
    logic                 w_stuck;
    logic                 w_latch_go;
    logic                 w_start;
    logic                 w_bit_val;
    logic                 r_from_low;
    logic                 r_rise_pend;
    logic                 r_ferr;
    logic [4:0]           r_bit_cnt;
    logic [GRB_PIX_W-1:0] r_shift;
    logic [PW-1:0]        r_pix_cnt;

    // w_count lags the true elapsed time by one cycle while a strobe is up,
    // so every threshold is compared against its value minus one.
    assign w_bit_val = (w_count >= CW'(T_THRESH_C - 1));

    // A rise that coincides with (or lands on) the latch cycle is held so the
    // next frame still starts from IDLE.
    assign w_start = w_rise | r_rise_pend;

    assign latch_o = (r_state == ST_LATCH);
    assign busy_o  = (r_state == ST_HIGH) || (r_state == ST_LOW) || (r_state == ST_STUCK);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_take_bit = 1'b0;
        w_stuck    = 1'b0;
        w_latch_go = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) w_next = ST_HIGH;
            end
            ST_HIGH: begin
                if (w_fall) begin
                    if (w_count < CW'(T_MIN_C - 1)) begin
                        w_next = r_from_low ? ST_LOW : ST_IDLE;
                    end else begin
                        w_take_bit = 1'b1;
                        w_next     = ST_LOW;
                    end
                end else if (w_count == CW'(T_MAX_C - 1)) begin
                    w_stuck = 1'b1;
                    w_next  = ST_STUCK;
                end
            end
            ST_STUCK: begin
                if (!w_di_s) w_next = ST_LOW;
            end
            ST_LOW: begin
                if (w_count == CW'(T_RESET_C - 1)) begin
                    w_latch_go = 1'b1;
                    w_next     = ST_LATCH;
                end else if (w_rise) begin
                    w_next = ST_HIGH;
                end
            end
            ST_LATCH: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Latch results are loaded on entry to LATCH so they are valid while
    // latch_o is high.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_from_low  <= 1'b0;
            r_rise_pend <= 1'b0;
            r_ferr      <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_pix_cnt   <= '0;
            pix_valid_o <= 1'b0;
            pix_data_o  <= '0;
            pix_index_o <= '0;
            pix_count_o <= '0;
            err_o       <= 1'b0;
        end else begin
            pix_valid_o <= 1'b0;

            if (r_state == ST_IDLE || r_state == ST_LOW) begin
                r_from_low <= (r_state == ST_LOW);
            end

            if (r_state == ST_IDLE) begin
                r_rise_pend <= 1'b0;
            end else if ((w_latch_go || r_state == ST_LATCH) && w_rise) begin
                r_rise_pend <= 1'b1;
            end

            if (w_take_bit) begin
                r_shift <= {r_shift[GRB_PIX_W-2:0], w_bit_val};
                if (r_bit_cnt == 5'd23) begin
                    r_bit_cnt <= '0;
                    if (r_pix_cnt < PW'(NUM_LEDS)) begin
                        pix_data_o  <= {r_shift[GRB_PIX_W-2:0], w_bit_val};
                        pix_index_o <= r_pix_cnt[IW-1:0];
                        pix_valid_o <= 1'b1;
                        r_pix_cnt   <= r_pix_cnt + 1'b1;
                    end else begin
`ifndef WS2812_RX_FORWARD_EN
                        err_o  <= 1'b1;
                        r_ferr <= 1'b1;
`endif
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            if (w_stuck) begin
                err_o  <= 1'b1;
                r_ferr <= 1'b1;
            end

            if (w_latch_go) begin
                pix_count_o <= r_pix_cnt;
                err_o       <= r_ferr | (r_bit_cnt != '0);
                r_ferr      <= 1'b0;
                r_bit_cnt   <= '0;
                r_pix_cnt   <= '0;
            end
        end
    end

`ifdef WS2812_RX_FORWARD_EN
    logic r_do;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_do <= 1'b0;
        end else begin
            r_do <= (r_pix_cnt >= PW'(NUM_LEDS)) & w_di_s;
        end
    end

    assign do_o = r_do;
`else
    assign do_o = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
module tb_ws2812_rx;

    localparam int NUM  = 8;
    localparam int TMIN = 7;
    localparam int TTH  = 30;
    localparam int TMAX = 100;
    localparam int TRES = 2500;
    localparam int GAP  = 2600;
`ifdef WS2812_RX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        di  = 1'b0;
    logic        pix_valid_o;
    logic [23:0] pix_data_o;
    logic [2:0]  pix_index_o;
    logic        latch_o;
    logic [3:0]  pix_count_o;
    logic        err_o;
    logic        busy_o;
    logic        do_o;

    ws2812_rx #(
        .NUM_LEDS     (NUM),
        .SYSTEM_CLOCK (50000000)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .di_i        (di),
        .pix_valid_o (pix_valid_o),
        .pix_data_o  (pix_data_o),
        .pix_index_o (pix_index_o),
        .latch_o     (latch_o),
        .pix_count_o (pix_count_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .do_o        (do_o)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int idx; logic [23:0] data; int cyc; } vrec_t;
    typedef struct { int cnt; logic err; int cyc; } lrec_t;
    vrec_t vq[$];
    lrec_t lq[$];
    int    dq[$];
    int    drun = 0;

    always @(negedge clk) begin
        if (pix_valid_o) vq.push_back('{int'(pix_index_o), pix_data_o, cyc});
        if (latch_o) lq.push_back('{int'(pix_count_o), err_o, cyc});
        if (do_o) drun++;
        else if (drun != 0) begin
            dq.push_back(drun);
            drun = 0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: high-pulse widths of one frame -> expected results.
    int          wq[$];
    logic [23:0] exp_px[$];
    logic [23:0] exp_fwd[$];
    int          exp_cnt;
    bit          exp_err;
    int          last_fall = 0;

    task automatic model();
        int nbits = 0;
        int npix  = 0;
        logic [23:0] acc = '0;
        exp_px.delete();
        exp_fwd.delete();
        exp_err = 1'b0;
        foreach (wq[i]) begin
            if (wq[i] >= TMAX) exp_err = 1'b1;
            else if (wq[i] >= TMIN) begin
                acc = {acc[22:0], (wq[i] >= TTH)};
                nbits++;
                if (nbits == 24) begin
                    nbits = 0;
                    npix++;
                    if (npix <= NUM) exp_px.push_back(acc);
                    else if (FWD) exp_fwd.push_back(acc);
                    else exp_err = 1'b1;
                end
            end
        end
        if (nbits != 0) exp_err = 1'b1;
        exp_cnt = (npix > NUM) ? NUM : npix;
    endtask

    task automatic add_pixel(input logic [23:0] p, input bit fixed);
        for (int b = 23; b >= 0; b--) begin
            if (p[b]) wq.push_back(fixed ? 40 : int'($urandom_range(60, 30)));
            else      wq.push_back(fixed ? 20 : int'($urandom_range(29, 8)));
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        di = 1'b1;
        repeat (hi) @(posedge clk);
        #1 di = 1'b0;
        last_fall = cyc;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame();
        model();
        vq.delete();
        lq.delete();
        dq.delete();
        foreach (wq[i]) pulse(wq[i], int'($urandom_range(40, 15)));
    endtask

    task automatic finish_frame(input string tag);
        logic [23:0] w;
        repeat (GAP) @(posedge clk);
        #1;
        check({tag, ".npix"}, 64'(vq.size()), 64'(exp_px.size()));
        foreach (exp_px[i]) begin
            if (i < vq.size()) begin
                check($sformatf("%s.data%0d", tag, i), 64'(vq[i].data), 64'(exp_px[i]));
                check($sformatf("%s.idx%0d", tag, i), 64'(vq[i].idx), 64'(i));
            end
        end
        check({tag, ".nlatch"}, 64'(lq.size()), 64'd1);
        if (lq.size() > 0) begin
            check({tag, ".count"}, 64'(lq[0].cnt), 64'(exp_cnt));
            check({tag, ".err"}, 64'(lq[0].err), 64'(exp_err));
        end
        check({tag, ".busy_end"}, 64'(busy_o), 64'd0);
        check({tag, ".do_pulses"}, 64'(dq.size()), 64'(24 * exp_fwd.size()));
        foreach (exp_fwd[k]) begin
            if (dq.size() == 24 * exp_fwd.size()) begin
                w = '0;
                for (int b = 0; b < 24; b++) w = {w[22:0], (dq[k*24+b] >= TTH)};
                check($sformatf("%s.fwd%0d", tag, k), 64'(w), 64'(exp_fwd[k]));
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({pix_valid_o, pix_data_o, pix_index_o, latch_o,
                                    pix_count_o, err_o, busy_o, do_o}), 64'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // One fixed pixel, latency of valid and latch
        wq.delete();
        add_pixel(24'hA53C0F, 1'b1);
        drive_frame();
        check("t1.busy", 64'(busy_o), 64'd1);
        finish_frame("t1");
        if (vq.size() > 0) begin
            check("t1.const", 64'(vq[0].data), 64'hA53C0F);
            check("t1.valid_lat", 64'(vq[0].cyc - last_fall), 64'd3);
        end
        if (lq.size() > 0) check("t1.latch_lat", 64'(lq[0].cyc - last_fall), 64'(TRES + 3));

        // 10 random pixels, 8 reported
        wq.delete();
        for (int p = 0; p < 10; p++) add_pixel(24'($urandom()), 1'b0);
        drive_frame();
        finish_frame("t2");

        // Threshold boundaries and glitches (leading glitch from idle, one mid-pixel)
        wq.delete();
        wq.push_back(5);
        for (int b = 0; b < 24; b++) begin
            wq.push_back((b % 3 == 0) ? 29 : (b % 3 == 1) ? 30 : 7);
            if (b == 11) wq.push_back(6);
        end
        drive_frame();
        finish_frame("t3");
        if (vq.size() > 0) check("t3.const", 64'(vq[0].data), 64'h492492);

        // Partial pixel
        wq.delete();
        for (int b = 0; b < 12; b++) wq.push_back(int'($urandom_range(60, 8)));
        drive_frame();
        finish_frame("t4");

        // Clean frame clears the error
        wq.delete();
        add_pixel(24'($urandom()), 1'b0);
        drive_frame();
        finish_frame("t5");

        // Stuck-high line
        wq.delete();
        wq.push_back(150);
        drive_frame();
        check("t6.err_mid", 64'(err_o), 64'd1);
        check("t6.no_valid", 64'(vq.size()), 64'd0);
        finish_frame("t6");

        wq.delete();
        add_pixel(24'($urandom()), 1'b0);
        add_pixel(24'($urandom()), 1'b0);
        drive_frame();
        finish_frame("t7");

        // Asynchronous reset mid-frame
        wq.delete();
        for (int p = 0; p < 3; p++) add_pixel(24'($urandom()), 1'b0);
        drive_frame();
        check("t8.npix_pre", 64'(vq.size()), 64'd3);
        #4 rst = 1'b1;
        #1;
        check("t8.async_clear", 64'({pix_valid_o, pix_data_o, pix_index_o, latch_o,
                                     pix_count_o, err_o, busy_o, do_o}), 64'd0);
        vq.delete();
        lq.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (GAP) @(posedge clk);
        #1;
        check("t8.no_latch", 64'(lq.size()), 64'd0);
        check("t8.no_valid", 64'(vq.size()), 64'd0);

        wq.delete();
        for (int p = 0; p < 2; p++) add_pixel(24'($urandom()), 1'b0);
        drive_frame();
        finish_frame("t9");

        // Random frame sizes
        for (int f = 0; f < 2; f++) begin
            wq.delete();
            for (int p = 0; p < int'($urandom_range(NUM, 1)); p++) add_pixel(24'($urandom()), 1'b0);
            drive_frame();
            finish_frame($sformatf("rnd%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
